// File: rtl/switch_debounce.sv
// Per-bit switch debouncer: two-flop synchronizer, saturating mismatch counter,
// registered debounced level plus one-cycle rise/fall/changed pulses.
module switch_debounce #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   localparam int            CW      = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             changed_q;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   // The counter holds the number of mismatch edges already seen; the edge that
   // finds it at CNT_MAX is the STABLE_CYCLES-th mismatch and commits the level.
   always_comb begin
      out_d  = out_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != out_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               out_d[i]  = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         out_q     <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q   <= sw_in;
         sync2_q   <= sync1_q;
         out_q     <= out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= |(rise_d | fall_d);
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign sw_out  = out_q;
   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a window-based reference model pushes the
// expected outputs every edge, a monitor pops and compares on the falling edge.
module tb_switch_debounce;

   localparam int SC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_in;
   logic [3:0] sw_out, sw_rise, sw_fall;
   logic       changed;
   logic [3:0] sw_out2, sw_rise2, sw_fall2;
   logic       changed2;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   switch_debounce #(.WIDTH(4), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .sw_in(sw_in),
      .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall), .changed(changed)
   );

   switch_debounce #(.WIDTH(4), .STABLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .sw_in(sw_in),
      .sw_out(sw_out2), .sw_rise(sw_rise2), .sw_fall(sw_fall2), .changed(changed2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: the synchronized value used at an edge is sw_in from two
   // edges earlier; a bit flips once the last SC used values all differ from it.
   typedef struct packed {
      logic [3:0] o;
      logic [3:0] r;
      logic [3:0] f;
      logic       c;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] hist[$];
   logic [3:0] m_s1 = '0, m_s2 = '0, m_out = '0;

   always @(posedge clk) begin
      exp_t       e;
      logic [3:0] nr, nf;
      bit         all_diff;
      nr = '0;
      nf = '0;
      if (rst) begin
         m_s1  = '0;
         m_s2  = '0;
         m_out = '0;
         hist.delete();
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > SC) void'(hist.pop_front());
         for (int b = 0; b < 4; b++) begin
            if (hist.size() == SC) begin
               all_diff = 1'b1;
               foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 1'b0;
               if (all_diff) begin
                  m_out[b] = ~m_out[b];
                  if (m_out[b]) nr[b] = 1'b1;
                  else          nf[b] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = sw_in;
      end
      e.o = m_out;
      e.r = nr;
      e.f = nf;
      e.c = |(nr | nf);
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("sw_out",  32'(sw_out),  32'(e.o));
         chk("sw_rise", 32'(sw_rise), 32'(e.r));
         chk("sw_fall", 32'(sw_fall), 32'(e.f));
         chk("changed", 32'(changed), 32'(e.c));
      end
   end

   initial begin
      rst   = 1'b1;
      sw_in = 4'hF;

      // Reset release with inputs high; dut2 runs with STABLE_CYCLES=2.
      cyc(3);
      chk("rst_out", 32'(sw_out), 32'h0);
      chk("rst_chg", 32'(changed), 32'h0);
      rst = 1'b0;
      cyc(3);
      chk("p2_out_e3", 32'(sw_out2), 32'h0);
      cyc(1);
      chk("p2_out_e4", 32'(sw_out2), 32'hF);
      chk("p2_rise_e4", 32'(sw_rise2), 32'hF);
      chk("p2_chg_e4", 32'(changed2), 32'h1);
      cyc(1);
      chk("p2_rise_e5", 32'(sw_rise2), 32'h0);
      cyc(12);
      chk("rel_out_e17", 32'(sw_out), 32'h0);
      cyc(1);
      chk("rel_out_e18", 32'(sw_out), 32'hF);
      chk("rel_rise_e18", 32'(sw_rise), 32'hF);
      chk("rel_chg_e18", 32'(changed), 32'h1);
      cyc(1);
      chk("rel_rise_e19", 32'(sw_rise), 32'h0);
      chk("rel_chg_e19", 32'(changed), 32'h0);

      // Glitch shorter than the threshold.
      sw_in = 4'h0;
      cyc(20);
      sw_in = 4'h4;
      cyc(10);
      sw_in = 4'h0;
      cyc(20);
      chk("glitch_out", 32'(sw_out), 32'h0);

      // Simultaneous opposite transitions.
      sw_in = 4'h8;
      cyc(20);
      chk("opp_pre", 32'(sw_out), 32'h8);
      sw_in = 4'h1;
      cyc(17);
      chk("opp_out_e17", 32'(sw_out), 32'h8);
      cyc(1);
      chk("opp_out_e18", 32'(sw_out), 32'h1);
      chk("opp_rise", 32'(sw_rise), 32'h1);
      chk("opp_fall", 32'(sw_fall), 32'h8);
      chk("opp_chg", 32'(changed), 32'h1);

      // Reset while bit0 counter sits at 10.
      sw_in = 4'h0;
      cyc(20);
      sw_in = 4'h1;
      cyc(12);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(17);
      chk("midrst_e17", 32'(sw_out[0]), 32'h0);
      cyc(1);
      chk("midrst_e18", 32'(sw_out[0]), 32'h1);
      chk("midrst_rise", 32'(sw_rise[0]), 32'h1);

      // Bounce on bit1, then settle high.
      sw_in = 4'h0;
      cyc(20);
      for (int k = 0; k < 20; k++) begin
         sw_in[1] = ~sw_in[1];
         cyc(1);
      end
      sw_in[1] = 1'b1;
      cyc(25);
      chk("bounce_out", 32'(sw_out[1]), 32'h1);

      // Randomized hold times, values and occasional resets.
      for (int p = 0; p < 300; p++) begin
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            cyc($urandom_range(1, 3));
            rst = 1'b0;
         end
         sw_in = 4'($urandom);
         cyc($urandom_range(1, 24));
      end

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
